// File: rtl/inst_mem_ctrl.sv
// Instruction-memory responder: serves IF fetches after WAIT_STATES stall cycles,
// with a side load port for filling the word-addressed storage.
module inst_mem_ctrl #(
  parameter int WAIT_STATES = 3,
  parameter int DEPTH_LOG2  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic        cancel,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] Instruction,
  output logic        ready,
  output logic        freeze,
  output logic        busy
);

  // state | meaning
  // IDLE  | no fetch outstanding, may accept rd_en
  // BUSY  | counting wait states for the latched index
  // DONE  | Instruction holds the fetched word, ready pulses unless cancelled
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           instr_q, instr_d;
  logic [31:0]           mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] rd_idx, ld_idx;
  logic                  unused_addr_bits;

  // Byte offset and bits above the storage depth alias away.
  assign rd_idx = addr[DEPTH_LOG2+1:2];
  assign ld_idx = ld_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0],
                              ld_addr[31:DEPTH_LOG2+2], ld_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: begin
        if (rd_en && !cancel) begin
          idx_d = rd_idx;
          if (WAIT_STATES == 0) begin
            state_d = DONE;
            instr_d = mem_q[rd_idx];
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
          instr_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
    end
  end

  // Storage survives reset; the comb read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_idx] <= ld_data;
  end

  assign Instruction = instr_q;
  assign ready       = (state_q == DONE) && !cancel;
  assign freeze      = !rst && rd_en && !ready && !cancel;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed bench for inst_mem_ctrl: a 3-wait-state instance and a 0-wait-state
// instance share stimulus; each vector names which instance it checks.
module tb_inst_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        cancel = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic [31:0] ld_data = 32'd0;

  logic [31:0] instr3, instr0;
  logic        ready3, ready0, freeze3, freeze0, busy3, busy0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_mem_ctrl #(.WAIT_STATES(3), .DEPTH_LOG2(8)) u3 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .addr(addr), .cancel(cancel),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .Instruction(instr3), .ready(ready3), .freeze(freeze3), .busy(busy3));

  inst_mem_ctrl #(.WAIT_STATES(0), .DEPTH_LOG2(8)) u0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .addr(addr), .cancel(cancel),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .Instruction(instr0), .ready(ready0), .freeze(freeze0), .busy(busy0));

  typedef struct {
    logic        sel0;
    logic        rd;
    logic [31:0] a;
    logic        cxl;
    logic        ld;
    logic [31:0] la;
    logic [31:0] ldd;
    logic        rdy;
    logic        frz;
    logic        bsy;
    logic        ci;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vf(input logic rd, input logic [31:0] a, input logic cxl,
                              input logic rdy, input logic frz, input logic bsy,
                              input logic ci, input logic [31:0] ins);
    vec_t t;
    t.sel0 = 1'b0; t.rd = rd; t.a = a; t.cxl = cxl;
    t.ld = 1'b0; t.la = 32'd0; t.ldd = 32'd0;
    t.rdy = rdy; t.frz = frz; t.bsy = bsy; t.ci = ci; t.ins = ins;
    return t;
  endfunction

  function automatic vec_t vld(input logic [31:0] la, input logic [31:0] d);
    vec_t t;
    t = vf(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    t.ld = 1'b1; t.la = la; t.ldd = d;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input vec_t t, input int row);
    logic        r, f, b;
    logic [31:0] i;
    @(posedge clk); #1;
    rd_en = t.rd; addr = t.a; cancel = t.cxl;
    ld_en = t.ld; ld_addr = t.la; ld_data = t.ldd;
    @(negedge clk);
    r = t.sel0 ? ready0  : ready3;
    f = t.sel0 ? freeze0 : freeze3;
    b = t.sel0 ? busy0   : busy3;
    i = t.sel0 ? instr0  : instr3;
    chk($sformatf("row%0d ready", row),  {31'd0, r}, {31'd0, t.rdy});
    chk($sformatf("row%0d freeze", row), {31'd0, f}, {31'd0, t.frz});
    chk($sformatf("row%0d busy", row),   {31'd0, b}, {31'd0, t.bsy});
    if (t.ci) chk($sformatf("row%0d instr", row), i, t.ins);
  endtask

  localparam logic [31:0] W10 = 32'hE3A0_1005;
  localparam logic [31:0] WD  = 32'hD0D0_D0D0;
  localparam logic [31:0] W0  = 32'h1111_0000;
  localparam logic [31:0] WY  = 32'hCAFE_F00D;
  localparam logic [31:0] WA  = 32'hAAAA_0001;
  localparam logic [31:0] WB  = 32'hBBBB_0002;
  localparam logic [31:0] WC  = 32'hCCCC_0003;

  task automatic fetch3(input logic [31:0] a, input logic [31:0] exp);
    tbl.push_back(vf(1, a, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(vf(1, a, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vf(1, a, 0, 1, 0, 1, 1, exp));
    tbl.push_back(vf(0, a, 0, 0, 0, 0, 1, exp));
  endtask

  initial begin
    vec_t t;

    // Reset: freeze forced low even with rd_en high, then reset values.
    @(posedge clk); #1;
    rd_en = 1'b1;
    @(negedge clk);
    chk("rst freeze", {31'd0, freeze3}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("post-rst instr", instr3, 32'd0);
    chk("post-rst ready", {31'd0, ready3}, 32'd0);
    chk("post-rst busy",  {31'd0, busy3}, 32'd0);
    chk("post-rst freeze", {31'd0, freeze3}, 32'd0);

    tbl.push_back(vld(32'h10, W10));
    tbl.push_back(vld(32'h40, WD));
    tbl.push_back(vld(32'h00, W0));
    fetch3(32'h10, W10);
    // Cancel in BUSY while the PC redirects to 0x40.
    tbl.push_back(vf(1, 32'h10, 0, 0, 1, 0, 0, 0));
    tbl.push_back(vf(1, 32'h10, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vf(1, 32'h40, 1, 0, 0, 1, 0, 0));
    fetch3(32'h40, WD);
    // Cancel in DONE suppresses ready, then IDLE.
    tbl.push_back(vf(1, 32'h10, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(vf(1, 32'h10, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vf(1, 32'h10, 1, 0, 0, 1, 0, 0));
    tbl.push_back(vf(0, 32'h10, 0, 0, 0, 0, 0, 0));
    // Cancel in IDLE blocks acceptance.
    tbl.push_back(vf(1, 32'h10, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vf(0, 32'h10, 0, 0, 0, 0, 0, 0));
    fetch3(32'h403, W0);
    // Load collision on the edge entering DONE: old word out, new word stored.
    tbl.push_back(vf(1, 32'h10, 0, 0, 1, 0, 0, 0));
    tbl.push_back(vf(1, 32'h10, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vf(1, 32'h10, 0, 0, 1, 1, 0, 0));
    t = vf(1, 32'h10, 0, 0, 1, 1, 0, 0);
    t.ld = 1'b1; t.la = 32'h10; t.ldd = WY;
    tbl.push_back(t);
    tbl.push_back(vf(1, 32'h10, 0, 1, 0, 1, 1, W10));
    tbl.push_back(vf(0, 32'h10, 0, 0, 0, 0, 1, W10));
    fetch3(32'h10, WY);

    foreach (tbl[n]) cyc(tbl[n], n);
    tbl.delete();

    // Reset during BUSY: pending fetch dropped, storage retained.
    cyc(vf(1, 32'h40, 0, 0, 1, 0, 0, 0), 100);
    cyc(vf(1, 32'h40, 0, 0, 1, 1, 0, 0), 101);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst freeze", {31'd0, freeze3}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("rst-busy instr", instr3, 32'd0);
    chk("rst-busy ready", {31'd0, ready3}, 32'd0);
    chk("rst-busy busy",  {31'd0, busy3}, 32'd0);
    fetch3(32'h40, WD);
    fetch3(32'h10, WY);

    // Zero wait states: back-to-back fetches, ready every other cycle.
    tbl.push_back(vld(32'h0, WA));
    t = vld(32'h4, WB); t.sel0 = 1'b1; tbl.push_back(t);
    t = vld(32'h8, WC); t.sel0 = 1'b1; tbl.push_back(t);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] pc, w;
      pc = 32'(4 * k);
      w  = (k == 0) ? WA : (k == 1) ? WB : WC;
      t = vf(1, pc, 0, 0, 1, 0, 0, 0); t.sel0 = 1'b1; tbl.push_back(t);
      t = vf(1, pc, 0, 1, 0, 1, 1, w); t.sel0 = 1'b1; tbl.push_back(t);
    end
    t = vf(0, 32'h0, 0, 0, 0, 0, 1, WC); t.sel0 = 1'b1; tbl.push_back(t);

    foreach (tbl[n]) cyc(tbl[n], 200 + n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Instruction-memory responder that serves fetch requests issued by the IF stage. It models a slow memory with a programmable number of wait states. While a fetch is outstanding it drives `freeze` back to IF, and it returns the instruction with a one-cycle `ready` pulse. A taken branch aborts an in-flight fetch through `cancel`. Word-addressed storage is filled through a dedicated load port, by the testbench or the boot loader.

## Interface
- `WAIT_STATES`, default 3: extra cycles spent in BUSY per fetch (0..15).
- `DEPTH_LOG2`, default 8: log2 of storage depth in 32-bit words.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `rd_en` input, 1 bit: IF requests the instruction at `addr`.
- `addr` input, 32 bits: byte address of the fetch (the PC).
- `cancel` input, 1 bit: branch taken / flush; abort any fetch in progress.
- `ld_en` input, 1 bit: write enable for the load port.
- `ld_addr` input, 32 bits: byte address for the load write.
- `ld_data` input, 32 bits: word to write.
- `Instruction` output, 32 bits: fetched word, registered; meaningful only while `ready`=1.
- `ready` output, 1 bit: one-cycle pulse; `Instruction` is valid.
- `freeze` output, 1 bit: stall request to IF, combinational.
- `busy` output, 1 bit: a fetch is outstanding (state BUSY or DONE).

## Operation
- Word index is `addr[DEPTH_LOG2+1:2]`.
  - `addr[1:0]` and the upper bits are ignored, so addresses alias and wrap modulo depth.
  - The same index rule applies to `ld_addr`.
- Storage contents are not affected by `rst`.
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - If `rd_en`=1 and `cancel`=0: latch the index.
  - If `WAIT_STATES`=0, go to DONE and load `Instruction` from storage.
  - Otherwise go to BUSY with `cnt` = `WAIT_STATES`-1.
- BUSY:
  - If `cancel`=1, go to IDLE.
  - Else if `cnt`=0, go to DONE and load `Instruction` from storage at the latched index.
  - Else decrement `cnt`.
- DONE:
  - `ready`=1 unless `cancel`=1, in which case `ready`=0.
  - Always go to IDLE next cycle; a new request needs a fresh IDLE acceptance.
- `freeze` = `rd_en` & ~`ready` & ~`cancel`. IF is never frozen on the cycle a branch redirects it.
- `busy` = (state is BUSY or DONE).
- The latched index is served. Changes on `addr` during BUSY without `cancel` are ignored; IF must hold the PC while frozen.
- Dropping `rd_en` mid-fetch does not abort it. The fetch completes and `ready` pulses.
- Load port:
  - Storage write happens on the clock edge when `ld_en`=1, in any state.
  - If the write and the `Instruction` load hit the same index on the same edge, `Instruction` receives the old word (read-before-write).
- `Instruction` holds its last loaded value outside DONE.

## Timing
- Reset values: state IDLE, `cnt`=0, `Instruction`=0, `ready`=0, `busy`=0.
  - `freeze`=0 in the cycle after reset deasserts unless `rd_en`=1.
  - `freeze` is forced to 0 while `rst`=1.
- Latency: request accepted in IDLE at cycle T, `ready`=1 at T+`WAIT_STATES`+1.
- Throughput: one instruction every `WAIT_STATES`+2 cycles for back-to-back fetches.
- `freeze` is high from T through T+`WAIT_STATES` and low at T+`WAIT_STATES`+1. IF advances its PC on the edge ending the `ready` cycle.
- Cancel:
  - Asserted in IDLE: no acceptance that cycle.
  - Asserted in BUSY: next state IDLE, no `ready` pulse.
  - Asserted in DONE: `ready` is suppressed.
- `rst` mid-fetch: next cycle is IDLE with all outputs at reset values; the pending fetch is discarded.

## Test plan
- Load and fetch with `WAIT_STATES`=3:
  - Stimulus: load `mem[0x10>>2]`=0xE3A01005, then hold `rd_en`=1, `addr`=0x10 from cycle T.
  - Required: `freeze`=1 at T..T+3; `ready`=1 with `Instruction`=0xE3A01005 at T+4; `freeze`=0 at T+4.
- `WAIT_STATES`=0, sequential PCs 0,4,8 with words A,B,C:
  - Stimulus: fetch each PC in turn.
  - Required: `ready` on every other cycle, `Instruction` sequence A,B,C; `freeze` alternates 1,0.
- Cancel mid-fetch with `WAIT_STATES`=3:
  - Stimulus: accept at T, `cancel`=1 at T+2 while `addr` switches to 0x40 (word D).
  - Required: no `ready` for the old address; new acceptance at T+3; `ready` with D at T+7.
- Cancel in DONE:
  - Stimulus: `cancel`=1 exactly at T+`WAIT_STATES`+1.
  - Required: `ready`=0 and `freeze`=0 that cycle; state IDLE next cycle.
- Reset and aliasing:
  - Stimulus: assert `rst` during BUSY.
  - Required: next cycle `Instruction`=0, `ready`=0, `busy`=0, and storage still holds loaded words.
  - Stimulus (`DEPTH_LOG2`=8): fetch 0x403.
  - Required: returns `mem[0]`.
- Load collision:
  - Stimulus: `ld_en` to the latched index on the edge entering DONE (old word X, new word Y).
  - Required: `ready` delivers X. A second fetch of the same index returns Y.
